// File: rtl/sc_ppfifo.sv
// sc_ppfifo: single-clock ping-pong FIFO with two equal buffers behind
// ppfifo-style write and read handshakes. Blocks are committed whole and
// handed to the reader in commit order.
module sc_ppfifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [1:0]            o_write_ready,
    input  logic [1:0]            i_write_activate,
    output logic [23:0]           o_write_size,
    input  logic                  i_write_stb,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    output logic                  o_read_ready,
    input  logic                  i_read_activate,
    output logic [23:0]           o_read_size,
    output logic [DATA_WIDTH-1:0] o_read_data,
    input  logic                  i_read_stb,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {EMPTY, WRITING, FULL, READING} buf_state_t;

    buf_state_t              state      [2];
    buf_state_t              state_next [2];
    logic [ADDR_WIDTH:0]     count      [2];
    logic [ADDR_WIDTH:0]     rd_ptr;
    logic                    oldest;
    logic [1:0]              act_prev;
    logic [DATA_WIDTH-1:0]   mem [2*DEPTH];
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    overflow;
    logic                    underflow;

    logic                    wr_busy, wr_sel, rd_busy, rd_sel;
    logic [1:0]              act_rise;
    logic                    claim_w0, claim_w1;
    logic                    wr_accept, wr_release, commit;
    logic                    rd_ready, rd_claim, rd_release, rd_accept;
    logic [ADDR_WIDTH-1:0]   rd_addr_next;
    logic [ADDR_WIDTH:0]     size_sel;

    // Only one buffer is ever WRITING and only one READING; decode which.
    assign wr_busy  = (state[0] == WRITING) || (state[1] == WRITING);
    assign wr_sel   = (state[1] == WRITING);
    assign rd_busy  = (state[0] == READING) || (state[1] == READING);
    assign rd_sel   = (state[1] == READING);

    // Write claims are edge-triggered; bit 0 wins a simultaneous rise.
    assign act_rise   = i_write_activate & ~act_prev;
    assign claim_w0   = act_rise[0] && (state[0] == EMPTY) && !wr_busy;
    assign claim_w1   = act_rise[1] && !act_rise[0] && (state[1] == EMPTY) && !wr_busy;
    assign wr_accept  = i_write_stb && wr_busy && (count[wr_sel] != DEPTH_CNT);
    assign wr_release = wr_busy && !i_write_activate[wr_sel];
    assign commit     = wr_release && ((count[wr_sel] != '0) || wr_accept);

    // Read claims are level-sensitive so an early activate waits for ready.
    assign rd_ready     = (state[oldest] == FULL) && !rd_busy;
    assign rd_claim     = i_read_activate && rd_ready;
    assign rd_release   = rd_busy && !i_read_activate;
    assign rd_accept    = i_read_stb && rd_busy && (rd_ptr != count[rd_sel]);
    assign rd_addr_next = rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) state[i] <= EMPTY;
        end else begin
            for (int i = 0; i < 2; i++) state[i] <= state_next[i];
        end
    end

    // Next-state: writer and reader never touch the same buffer in a cycle.
    always_comb begin
        state_next[0] = state[0];
        state_next[1] = state[1];
        if (claim_w0) state_next[0] = WRITING;
        if (claim_w1) state_next[1] = WRITING;
        if (wr_release) state_next[wr_sel] = commit ? FULL : EMPTY;
        if (rd_claim) state_next[oldest] = READING;
        if (rd_release) state_next[rd_sel] = EMPTY;
    end

    // Handshake outputs decoded from registered state.
    always_comb begin
        o_write_ready[0] = (state[0] == EMPTY);
        o_write_ready[1] = (state[1] == EMPTY);
        o_write_size     = 24'(DEPTH);
        o_read_ready     = rd_ready;
        size_sel         = '0;
        if (rd_ready)     size_sel = count[oldest];
        else if (rd_busy) size_sel = count[rd_sel];
        o_read_size      = 24'(size_sel);
        o_read_data      = rd_data;
        o_overflow       = overflow;
        o_underflow      = underflow;
    end

    // Counts, pointers, commit order and the registered error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) count[i] <= '0;
            rd_ptr    <= '0;
            oldest    <= 1'b0;
            act_prev  <= 2'b00;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rd_release && (rd_sel == 1'(i)))
                    count[i] <= '0;
                else if (wr_accept && (wr_sel == 1'(i)))
                    count[i] <= count[i] + (ADDR_WIDTH + 1)'(1);
            end
            if (rd_claim)       rd_ptr <= '0;
            else if (rd_accept) rd_ptr <= rd_ptr + (ADDR_WIDTH + 1)'(1);
            // A commit with nothing else queued or draining becomes the oldest.
            if (rd_release)
                oldest <= ~oldest;
            else if (commit && (state[~wr_sel] != FULL) && (state[~wr_sel] != READING))
                oldest <= wr_sel;
            act_prev  <= i_write_activate;
            overflow  <= i_write_stb && !wr_accept;
            underflow <= i_read_stb && !rd_accept;
        end
    end

    // Registered read port: word 0 on claim, next word on each strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_claim) begin
            rd_data <= mem[{oldest, {ADDR_WIDTH{1'b0}}}];
        end else if (rd_accept) begin
            rd_data <= mem[{rd_sel, rd_addr_next}];
        end
    end

    // Buffer storage, not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[{wr_sel, count[wr_sel][ADDR_WIDTH-1:0]}] <= i_write_data;
    end

endmodule

// File: doc/sc_ppfifo.md
# sc_ppfifo

Single-clock ping-pong FIFO: two equal buffers behind the standard ppfifo write-port handshake (ready/activate/size/stb) and read-port handshake (ready/activate/size/stb). It is the responder for any ppfifo producer or consumer engine, including the BRAM-to-ppfifo adapters and the host DMA paths, in designs where both sides share one clock. Buffers are filled and drained as whole blocks. Blocks are delivered to the reader strictly in the order they were committed.

## Interface

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 9, log2 of words per buffer; each buffer holds DEPTH = 2^ADDR_WIDTH words.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, asynchronous, active-low.
- o_write_ready  out  2  bit i high when buffer i is empty and not activated.
- i_write_activate  in  2  writer claims buffer i.
- o_write_size  out  24  constant DEPTH.
- i_write_stb  in  1  write i_write_data into the active buffer.
- i_write_data  in  DATA_WIDTH  write word.
- o_read_ready  out  1  oldest committed buffer is available.
- i_read_activate  in  1  reader claims the oldest committed buffer.
- o_read_size  out  24  word count of the block offered or claimed.
- o_read_data  out  DATA_WIDTH  word at the read pointer.
- i_read_stb  in  1  consume the current word.
- o_overflow  out  1  one-cycle pulse: a write strobe was dropped.
- o_underflow  out  1  one-cycle pulse: a read strobe was dropped.

## Operation

- Buffer states, one per buffer: EMPTY, WRITING, FULL, READING. Each buffer carries a count of ADDR_WIDTH+1 bits.
- EMPTY→WRITING: i_write_activate[i] rises while o_write_ready[i]=1. If both activate bits rise in the same cycle, only bit 0 is honored; bit 1 is ignored.
- While WRITING: each i_write_stb writes mem[i][count] and increments count. A strobe with count==DEPTH, or with no buffer WRITING, is dropped and o_overflow pulses.
- WRITING→FULL: activate bit falls with count>0. The buffer is appended to the commit order.
- WRITING→EMPTY: activate bit falls with count==0. The buffer is not queued.
- Commit order: a 1-bit oldest pointer plus per-buffer FULL flags. With two FULL buffers, the earlier-committed buffer is offered first.
- o_read_ready=1 and o_read_size=count when the oldest buffer is FULL and no buffer is READING.
- FULL→READING: i_read_activate rises while o_read_ready=1. An activate with o_read_ready=0 is ignored until ready rises, and is then accepted.
- While READING:
  - o_read_data shows the word at the read pointer.
  - Each i_read_stb advances the pointer.
  - A strobe after count words have been consumed is dropped and o_underflow pulses.
- READING→EMPTY: i_read_activate falls, whether or not all words were consumed. Count is cleared and the oldest pointer toggles.
- Write and read operate concurrently on different buffers. A buffer never changes state by both paths in one cycle.

## Timing

- Reset values:
  - o_write_ready=2'b11.
  - o_read_ready=0, o_read_size=0, o_read_data=0.
  - o_overflow=0, o_underflow=0.
  - o_write_size=DEPTH (constant).
  - All counts and pointers are 0 and all buffers are EMPTY.
- Assertion of reset mid-operation discards all data immediately. Outputs return to their reset values asynchronously.
- Ready drop after claim: o_write_ready[i] and o_read_ready fall on the cycle after the activate is sampled high.
- Write ready returns: o_write_ready[i] rises 1 cycle after READING→EMPTY. It also rises 1 cycle after a zero-count release.
- Read ready returns: o_read_ready rises 1 cycle after WRITING→FULL, provided no buffer is READING.
- Writes: strobes are accepted every cycle. Data is written at the clock edge where i_write_stb is high; i_write_activate may fall on the cycle after the last strobe.
- Read data latency:
  - o_read_data is registered.
  - Word 0 is valid from the cycle after activate is sampled.
  - After a strobe at cycle T, the next word is valid at T+1.
  - The reader may strobe every cycle.
- o_overflow and o_underflow are registered and pulse on the cycle after the offending strobe.

## Test plan

- Basic block: after reset, activate bit0 and write 4 words 0xA0..0xA3, then drop activate. Expect o_read_ready=1 one cycle later, o_read_size=4, reads return 0xA0..0xA3 in order, and o_write_ready returns to 2'b11.
- Ping-pong order: commit buffer1 (3 words, 0x10..) and then buffer0 (2 words, 0x20..). Expect the first read to have o_read_size=3 with data 0x10..0x12, and the second read o_read_size=2 with data 0x20..0x21.
- Full buffer: write 512 words plus 1 extra strobe. Expect one o_overflow pulse, o_read_size=512, and the last word read equals word 511.
- Zero-length release: activate bit0 and drop it with no strobes. Expect o_read_ready to stay 0 and o_write_ready[0] to be 1 again one cycle later.
- Early read release: on a 6-word block, read 2 words and drop activate. Expect o_write_ready for that buffer to rise one cycle later. Then strobe with no activate and expect one o_underflow pulse.
- Reset mid-read: assert rst while READING. Expect immediate reset values on every output and no stale block offered after release.
